// File: rtl/bp_bht_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : bp_bht_ctrl
// Brief    : Fetch-stage branch direction predictor: a table of 2-bit saturating
//            counters, registered next-PC prediction, training and redirects.
// Revision : 1.0 - initial release
// ============================================================================
module bp_bht_ctrl #(
    parameter int         BHT_ENTRIES = 64,
    parameter logic [1:0] INIT_CTR    = 2'b01
) (
    input  logic        clk,
    input  logic        rst,
    output logic        bp_ready,
    input  logic        fe_valid,
    input  logic [31:0] fe_pc,
    input  logic        dec_is_branch,
    input  logic [31:0] dec_target,
    output logic        pred_valid,
    output logic        pred_taken,
    output logic [31:0] pred_npc,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic        upd_taken,
    input  logic [31:0] upd_target,
    input  logic        upd_pred_taken,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc
);

    localparam int                 c_IDX_W    = $clog2(BHT_ENTRIES);
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(BHT_ENTRIES - 1);
    localparam logic [0:0]         c_ST_INIT  = 1'b0;
    localparam logic [0:0]         c_ST_RUN   = 1'b1;

    logic [0:0]         r_state;
    logic [0:0]         w_state_nxt;
    logic [c_IDX_W-1:0] r_init_idx;
    logic [c_IDX_W-1:0] w_init_idx_nxt;
    logic [1:0]         r_ctr [BHT_ENTRIES];

    logic               r_pred_valid;
    logic               r_pred_taken;
    logic [31:0]        r_pred_npc;
    logic               r_redirect_valid;
    logic [31:0]        r_redirect_pc;

    logic               w_run;
    logic               w_mispredict;
    logic               w_lookup;
    logic               w_pred_taken;
    logic [31:0]        w_pred_npc;
    logic [c_IDX_W-1:0] w_lu_idx;
    logic [c_IDX_W-1:0] w_up_idx;
    logic [1:0]         w_up_ctr;
    logic [1:0]         w_up_ctr_nxt;

    assign w_run    = (r_state == c_ST_RUN);
    assign w_lu_idx = fe_pc[c_IDX_W+1:2];
    assign w_up_idx = upd_pc[c_IDX_W+1:2];

    // A mispredict squashes the same-cycle lookup: that fetch is wrong-path.
    assign w_mispredict = w_run & upd_valid & (upd_taken != upd_pred_taken);
    assign w_lookup     = w_run & fe_valid & ~w_mispredict;

    // Lookup reads the table before this cycle's update lands.
    assign w_pred_taken = dec_is_branch & r_ctr[w_lu_idx][1];
    assign w_pred_npc   = w_pred_taken ? dec_target : fe_pc + 32'd4;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_ST_INIT;
            r_init_idx <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_init_idx <= w_init_idx_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_init_idx_nxt = r_init_idx;
        if (r_state == c_ST_INIT) begin
            w_init_idx_nxt = r_init_idx + c_IDX_W'(1);
            if (r_init_idx == c_LAST_IDX) begin
                w_state_nxt    = c_ST_RUN;
                w_init_idx_nxt = '0;
            end
        end
    end

    always_comb begin
        w_up_ctr     = r_ctr[w_up_idx];
        w_up_ctr_nxt = w_up_ctr;
        if (upd_taken) begin
            if (w_up_ctr != 2'b11) w_up_ctr_nxt = w_up_ctr + 2'd1;
        end else begin
            if (w_up_ctr != 2'b00) w_up_ctr_nxt = w_up_ctr - 2'd1;
        end
    end

    // Table contents are established by the init walk, so no reset is needed.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (!w_run) begin
                r_ctr[r_init_idx] <= INIT_CTR;
            end else if (upd_valid) begin
                r_ctr[w_up_idx] <= w_up_ctr_nxt;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pred_valid     <= 1'b0;
            r_pred_taken     <= 1'b0;
            r_pred_npc       <= '0;
            r_redirect_valid <= 1'b0;
            r_redirect_pc    <= '0;
        end else begin
            r_pred_valid     <= w_lookup;
            r_redirect_valid <= w_mispredict;
            if (w_lookup) begin
                r_pred_taken <= w_pred_taken;
                r_pred_npc   <= w_pred_npc;
            end
            if (w_mispredict) begin
                r_redirect_pc <= upd_taken ? upd_target : upd_pc + 32'd4;
            end
        end
    end

    assign bp_ready       = w_run;
    assign pred_valid     = r_pred_valid;
    assign pred_taken     = r_pred_taken;
    assign pred_npc       = r_pred_npc;
    assign redirect_valid = r_redirect_valid;
    assign redirect_pc    = r_redirect_pc;

endmodule
`default_nettype wire

// File: tb/tb_bp_bht_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_bp_bht_ctrl
// Brief    : Directed plus randomized bench for bp_bht_ctrl against a
//            behavioural counter-table model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bp_bht_ctrl;

    localparam int c_ENT = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic        bp_ready;
    logic        fe_valid;
    logic [31:0] fe_pc;
    logic        dec_is_branch;
    logic [31:0] dec_target;
    logic        pred_valid;
    logic        pred_taken;
    logic [31:0] pred_npc;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        upd_pred_taken;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    bp_bht_ctrl #(.BHT_ENTRIES(c_ENT), .INIT_CTR(2'b01)) dut (
        .clk            (clk),
        .rst            (rst),
        .bp_ready       (bp_ready),
        .fe_valid       (fe_valid),
        .fe_pc          (fe_pc),
        .dec_is_branch  (dec_is_branch),
        .dec_target     (dec_target),
        .pred_valid     (pred_valid),
        .pred_taken     (pred_taken),
        .pred_npc       (pred_npc),
        .upd_valid      (upd_valid),
        .upd_pc         (upd_pc),
        .upd_taken      (upd_taken),
        .upd_target     (upd_target),
        .upd_pred_taken (upd_pred_taken),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    // Model state: counter values as plain integers plus a count of init cycles.
    int          m_ctr [c_ENT];
    int          m_init;
    bit          exp_ready;
    bit          exp_pv;
    bit          exp_pt;
    logic [31:0] exp_npc;
    bit          exp_rv;
    logic [31:0] exp_rpc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        bit mis;
        int li;
        int ui;
        if (rst) begin
            m_init  = 0;
            exp_pv  = 0;
            exp_pt  = 0;
            exp_npc = '0;
            exp_rv  = 0;
            exp_rpc = '0;
        end else if (m_init < c_ENT) begin
            m_init++;
            exp_pv = 0;
            exp_rv = 0;
            if (m_init == c_ENT) foreach (m_ctr[i]) m_ctr[i] = 1;
        end else begin
            mis    = upd_valid && (upd_taken != upd_pred_taken);
            li     = int'((fe_pc >> 2) % c_ENT);
            ui     = int'((upd_pc >> 2) % c_ENT);
            exp_pv = fe_valid && !mis;
            if (exp_pv) begin
                exp_pt  = dec_is_branch && (m_ctr[li] >= 2);
                exp_npc = exp_pt ? dec_target : fe_pc + 32'd4;
            end
            exp_rv = mis;
            if (mis) exp_rpc = upd_taken ? upd_target : upd_pc + 32'd4;
            if (upd_valid) begin
                if (upd_taken) m_ctr[ui] = (m_ctr[ui] >= 3) ? 3 : m_ctr[ui] + 1;
                else           m_ctr[ui] = (m_ctr[ui] <= 0) ? 0 : m_ctr[ui] - 1;
            end
        end
        exp_ready = (m_init >= c_ENT);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic set_fe(input bit v, input logic [31:0] pc, input bit br, input logic [31:0] tgt);
        fe_valid      = v;
        fe_pc         = pc;
        dec_is_branch = br;
        dec_target    = tgt;
    endtask

    task automatic set_upd(input bit v, input logic [31:0] pc, input bit tk,
                           input logic [31:0] tgt, input bit ptk);
        upd_valid      = v;
        upd_pc         = pc;
        upd_taken      = tk;
        upd_target     = tgt;
        upd_pred_taken = ptk;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("bp_ready", 32'(bp_ready), 32'(exp_ready));
            check("pred_valid", 32'(pred_valid), 32'(exp_pv));
            check("pred_taken", 32'(pred_taken), 32'(exp_pt));
            check("pred_npc", pred_npc, exp_npc);
            check("redirect_valid", 32'(redirect_valid), 32'(exp_rv));
            if (exp_rv) check("redirect_pc", redirect_pc, exp_rpc);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: bench did not finish, compared %0d", n_cmp);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        set_fe(1'b0, 32'h0, 1'b0, 32'h0);
        set_upd(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        foreach (m_ctr[i]) m_ctr[i] = 0;
        m_init = 0;
        #2;
        tick();
        chk_en = 1'b1;
        check("reset bp_ready", 32'(bp_ready), 32'd0);
        check("reset pred_npc", pred_npc, 32'h0);

        // Init walk with a lookup held the whole time.
        rst = 1'b0;
        set_fe(1'b1, 32'h0, 1'b0, 32'h0);
        repeat (63) tick();
        check("init cycle 63 bp_ready", 32'(bp_ready), 32'd0);
        tick();
        check("init done bp_ready", 32'(bp_ready), 32'd1);
        check("init done pred_valid", 32'(pred_valid), 32'd0);
        tick();
        check("first pred_valid", 32'(pred_valid), 32'd1);

        // Weakly not-taken after init.
        set_fe(1'b1, 32'h100, 1'b1, 32'h80);
        tick();
        check("wnt pred_taken", 32'(pred_taken), 32'd0);
        check("wnt pred_npc", pred_npc, 32'h104);

        // Train up, saturate high, then train down and saturate low.
        set_fe(1'b0, 32'h100, 1'b1, 32'h80);
        set_upd(1'b1, 32'h100, 1'b1, 32'h80, 1'b0);
        repeat (2) tick();
        set_upd(1'b0, 32'h100, 1'b1, 32'h80, 1'b0);
        set_fe(1'b1, 32'h100, 1'b1, 32'h80);
        tick();
        check("trained pred_taken", 32'(pred_taken), 32'd1);
        check("trained pred_npc", pred_npc, 32'h80);
        set_fe(1'b0, 32'h100, 1'b1, 32'h80);
        set_upd(1'b1, 32'h100, 1'b1, 32'h80, 1'b1);
        repeat (4) tick();
        set_upd(1'b1, 32'h100, 1'b0, 32'h80, 1'b1);
        repeat (3) tick();
        set_upd(1'b0, 32'h100, 1'b0, 32'h80, 1'b0);
        set_fe(1'b1, 32'h100, 1'b1, 32'h80);
        tick();
        check("saturated-high then 3 NT pred_taken", 32'(pred_taken), 32'd0);
        set_fe(1'b0, 32'h100, 1'b1, 32'h80);
        set_upd(1'b1, 32'h100, 1'b0, 32'h80, 1'b0);
        repeat (2) tick();
        set_upd(1'b1, 32'h100, 1'b1, 32'h80, 1'b1);
        repeat (2) tick();
        set_upd(1'b0, 32'h100, 1'b0, 32'h80, 1'b0);
        set_fe(1'b1, 32'h100, 1'b1, 32'h80);
        tick();
        check("saturated-low then 2 T pred_taken", 32'(pred_taken), 32'd1);

        // Redirects in both directions.
        set_fe(1'b0, 32'h0, 1'b0, 32'h0);
        set_upd(1'b1, 32'h200, 1'b1, 32'h40, 1'b0);
        tick();
        check("redirect taken valid", 32'(redirect_valid), 32'd1);
        check("redirect taken pc", redirect_pc, 32'h40);
        set_upd(1'b0, 32'h200, 1'b0, 32'h40, 1'b0);
        tick();
        check("redirect one-shot", 32'(redirect_valid), 32'd0);
        set_upd(1'b1, 32'h200, 1'b0, 32'h40, 1'b1);
        tick();
        check("redirect not-taken pc", redirect_pc, 32'h204);

        // Mispredict squashes a same-cycle lookup.
        set_fe(1'b1, 32'h300, 1'b1, 32'h500);
        set_upd(1'b1, 32'h200, 1'b1, 32'h40, 1'b0);
        tick();
        check("squash pred_valid", 32'(pred_valid), 32'd0);
        check("squash redirect_valid", 32'(redirect_valid), 32'd1);

        // Shared entry (0x100 and 0x200) now at 3: lookup sees the old value.
        set_fe(1'b1, 32'h100, 1'b1, 32'h80);
        set_upd(1'b1, 32'h200, 1'b0, 32'h40, 1'b0);
        repeat (2) tick();
        check("read-before-write pred_taken", 32'(pred_taken), 32'd1);
        set_upd(1'b0, 32'h200, 1'b0, 32'h40, 1'b0);
        tick();
        check("after update pred_taken", 32'(pred_taken), 32'd0);
        check("after update pred_npc", pred_npc, 32'h104);

        // Reset in the middle of init restarts the walk.
        set_fe(1'b1, 32'h0, 1'b0, 32'h0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (30) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (63) tick();
        check("restart cycle 63 bp_ready", 32'(bp_ready), 32'd0);
        tick();
        check("restart done bp_ready", 32'(bp_ready), 32'd1);
        set_fe(1'b1, 32'hFFFF_FFFC, 1'b0, 32'h1234);
        tick();
        check("wrap pred_valid", 32'(pred_valid), 32'd1);
        check("wrap pred_npc", pred_npc, 32'h0);

        // Randomized traffic with frequent index collisions and rare resets.
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 599) == 0);
            set_fe(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)), $urandom);
            set_upd(1'($urandom_range(0, 1)),
                    ($urandom_range(0, 2) == 0) ? fe_pc : $urandom,
                    1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 3) == 0) upd_pred_taken = upd_taken;
            tick();
        end

        rst = 1'b0;
        set_fe(1'b0, 32'h0, 1'b0, 32'h0);
        set_upd(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        tick();
        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
